// File: rtl/hiscore_upload_reader_pkg.sv
// Shared types and constants for the hiscore upload (read-back) responder.
package hiscore_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ACK = 3'd1,
    READY    = 3'd2,
    FETCH    = 3'd3,
    RELEASE  = 3'd4
  } hs_state_e;

  // Returned for any address past the end of the save image.
  localparam logic [7:0] OOR_BYTE = 8'hFF;

endpackage

// File: rtl/hiscore_upload_reader_if.sv
// HPS ioctl upload bundle: the HPS side is the master, the core responder the slave.
interface hiscore_ioctl_if;

  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait
  );

endinterface

// File: rtl/hiscore_upload_reader_ram_port_mux.sv
// 2:1 RAM port mux between the game CPU and the upload reader; lives in emu next to the reader.
module ram_port_mux #(
  parameter int AW = 10
) (
  input  logic          ram_sel,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic [AW-1:0] up_addr,
  input  logic          up_rd,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd
);

  // Select the port owner.
  always_comb begin
    ram_addr = cpu_addr;
    ram_rd   = cpu_rd;
    if (ram_sel) begin
      ram_addr = up_addr;
      ram_rd   = up_rd;
    end else begin
      ram_addr = cpu_addr;
      ram_rd   = cpu_rd;
    end
  end

endmodule

// File: rtl/hiscore_upload_reader.sv
// Serves HPS upload reads from work/NVRAM: pauses the CPU, borrows the RAM port,
// returns one byte per ioctl_rd and tracks byte count and checksum of the image.
module hiscore_upload_reader
  import hiscore_pkg::*;
#(
  parameter int AW      = 10,
  parameter int SIZE    = 1024,
  parameter int RAM_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          RESET_N,
  hiscore_ioctl_if.slave ioctl,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          ram_sel,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic [AW:0]   byte_count,
  output logic [7:0]    checksum
);

  localparam logic [24:0] SIZE_ADDR = 25'(SIZE);
  localparam logic [2:0]  LAT_LOAD  = 3'(RAM_LAT);
  localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_MAX   = {(AW+1){1'b1}};

  hs_state_e       state_q, state_d;
  logic            pause_req_q, pause_req_d;
  logic            wait_q, wait_d;
  logic            sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d;
  logic [7:0]      din_q, din_d;
  logic [2:0]      lat_q, lat_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      sum_q, sum_d;
  logic            busy_q, busy_d;
  logic            in_range_s;

  assign in_range_s = (ioctl.ioctl_addr < SIZE_ADDR);

  // State and output registers.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      pause_req_q <= 1'b0;
      wait_q      <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      din_q       <= 8'h00;
      lat_q       <= 3'd0;
      count_q     <= '0;
      sum_q       <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_req_q <= pause_req_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      din_q       <= din_d;
      lat_q       <= lat_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pause_req_d = pause_req_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    din_d       = din_q;
    lat_d       = lat_q;
    count_d     = count_q;
    sum_d       = sum_q;

    case (state_q)
      IDLE: begin
        wait_d = 1'b0;
        if (ioctl.ioctl_upload && !pause_ack) begin
          pause_req_d = 1'b1;
          wait_d      = 1'b1;
          count_d     = '0;
          sum_d       = 8'h00;
          state_d     = WAIT_ACK;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_ACK: begin
        if (!ioctl.ioctl_upload) begin
          pause_req_d = 1'b0;
          sel_d       = 1'b0;
          wait_d      = 1'b0;
          state_d     = RELEASE;
        end else if (pause_ack) begin
          sel_d   = 1'b1;
          wait_d  = 1'b0;
          state_d = READY;
        end else begin
          state_d = WAIT_ACK;
        end
      end

      READY: begin
        if (ioctl.ioctl_rd && in_range_s) begin
          // A falling upload is handled once the fetch completes.
          addr_d  = ioctl.ioctl_addr[AW-1:0];
          rd_d    = 1'b1;
          wait_d  = 1'b1;
          lat_d   = LAT_LOAD;
          state_d = FETCH;
        end else if (ioctl.ioctl_rd || !ioctl.ioctl_upload) begin
          if (ioctl.ioctl_rd) begin
            din_d = OOR_BYTE;
          end else begin
            din_d = din_q;
          end
          if (ioctl.ioctl_upload) begin
            state_d = READY;
          end else begin
            pause_req_d = 1'b0;
            sel_d       = 1'b0;
            state_d     = RELEASE;
          end
        end else begin
          state_d = READY;
        end
      end

      FETCH: begin
        if (lat_q == 3'd0) begin
          din_d  = ram_q;
          sum_d  = sum_q + ram_q;
          wait_d = 1'b0;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end else begin
            count_d = count_q;
          end
          if (ioctl.ioctl_upload) begin
            state_d = READY;
          end else begin
            pause_req_d = 1'b0;
            sel_d       = 1'b0;
            state_d     = RELEASE;
          end
        end else begin
          lat_d   = lat_q - 3'd1;
          state_d = FETCH;
        end
      end

      RELEASE: begin
        pause_req_d = 1'b0;
        sel_d       = 1'b0;
        wait_d      = 1'b0;
        if (!pause_ack) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end

      default: begin
        pause_req_d = 1'b0;
        sel_d       = 1'b0;
        wait_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = wait_q;
  assign pause_req        = pause_req_q;
  assign ram_sel          = sel_q;
  assign ram_addr         = addr_q;
  assign ram_rd           = rd_q;
  assign busy             = busy_q;
  assign byte_count       = count_q;
  assign checksum         = sum_q;

endmodule

// File: tb/tb_hiscore_upload_reader.sv
// Directed bench: a RAM_LAT=1 reader checked from vector tables, a RAM_LAT=3 reader for the mid-fetch abort.
module tb_hiscore_upload_reader;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          waits;
    int          pulses;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upload = 1'b0;
  logic        rd = 1'b0;
  logic [24:0] addr = 25'd0;
  logic        ack = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mem [1024];

  hiscore_ioctl_if if1 ();
  hiscore_ioctl_if if3 ();
  assign if1.ioctl_upload = upload;
  assign if1.ioctl_rd     = rd;
  assign if1.ioctl_addr   = addr;
  assign if3.ioctl_upload = upload;
  assign if3.ioctl_rd     = rd;
  assign if3.ioctl_addr   = addr;

  logic       pause_req1, ram_sel1, ram_rd1, busy1;
  logic [9:0] ram_addr1;
  logic [7:0] ram_q1, cs1;
  logic [10:0] bc1;
  logic       pause_req3, ram_sel3, ram_rd3, busy3;
  logic [9:0] ram_addr3;
  logic [7:0] ram_q3, cs3;
  logic [10:0] bc3;

  hiscore_upload_reader #(.AW(10), .SIZE(1024), .RAM_LAT(1)) dut1 (
    .clk_sys(clk), .RESET_N(rst_n), .ioctl(if1.slave),
    .pause_req(pause_req1), .pause_ack(ack), .ram_sel(ram_sel1),
    .ram_addr(ram_addr1), .ram_rd(ram_rd1), .ram_q(ram_q1),
    .busy(busy1), .byte_count(bc1), .checksum(cs1)
  );

  hiscore_upload_reader #(.AW(10), .SIZE(1024), .RAM_LAT(3)) dut3 (
    .clk_sys(clk), .RESET_N(rst_n), .ioctl(if3.slave),
    .pause_req(pause_req3), .pause_ack(ack), .ram_sel(ram_sel3),
    .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_q(ram_q3),
    .busy(busy3), .byte_count(bc3), .checksum(cs3)
  );

  always #5 clk = ~clk;

  // RAM models: data appears RAM_LAT clocks after the read strobe.
  logic [7:0] p1, s0, s1, s2;
  always @(posedge clk) begin
    if (ram_rd1) p1 <= mem[ram_addr1];
    if (ram_rd3) s0 <= mem[ram_addr3];
    s1 <= s0;
    s2 <= s1;
  end
  assign ram_q1 = p1;
  assign ram_q3 = s2;

  int rd_pulses1 = 0;
  int sel_cycles1 = 0;
  always @(posedge clk) begin
    if (ram_rd1) rd_pulses1 <= rd_pulses1 + 1;
    if (ram_sel1) sel_cycles1 <= sel_cycles1 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_read(input vec_t v, input string tag);
    int wc;
    int p0;
    p0 = rd_pulses1;
    rd = 1'b1;
    addr = v.addr;
    tick();
    rd = 1'b0;
    chk({tag, " ram_rd"}, {31'd0, ram_rd1}, (v.pulses != 0) ? 32'd1 : 32'd0);
    wc = 0;
    while (if1.ioctl_wait && wc < 20) begin
      wc++;
      tick();
    end
    tick();
    chk({tag, " din"}, {24'd0, if1.ioctl_din}, {24'd0, v.din});
    chk({tag, " wait_clocks"}, wc, v.waits);
    chk({tag, " rd_pulses"}, rd_pulses1 - p0, v.pulses);
  endtask

  task automatic start_session();
    upload = 1'b1;
    ack = 1'b0;
    tick();
    chk("start pause_req", {31'd0, pause_req1}, 32'd1);
    chk("start wait", {31'd0, if1.ioctl_wait}, 32'd1);
    chk("start busy", {31'd0, busy1}, 32'd1);
    chk("start byte_count clr", {21'd0, bc1}, 32'd0);
    tick();
    tick();
    chk("wait_ack no sel", {31'd0, ram_sel1}, 32'd0);
    ack = 1'b1;
    tick();
    chk("ready ram_sel", {31'd0, ram_sel1}, 32'd1);
    chk("ready wait", {31'd0, if1.ioctl_wait}, 32'd0);
  endtask

  vec_t tbl1 [6];
  vec_t tbl2 [4];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'hFF; mem[5] = 8'hFF; mem[6] = 8'hFF; mem[7] = 8'hFF;
    mem[1023] = 8'h04;

    tbl1[0] = '{25'd0,          8'h11, 2, 1};
    tbl1[1] = '{25'd1,          8'h22, 2, 1};
    tbl1[2] = '{25'd1024,       8'hFF, 0, 0};
    tbl1[3] = '{25'd2,          8'h33, 2, 1};
    tbl1[4] = '{25'd3,          8'h44, 2, 1};
    tbl1[5] = '{25'h1FF_FFFF,   8'hFF, 0, 0};
    tbl2[0] = '{25'd4, 8'hFF, 2, 1};
    tbl2[1] = '{25'd5, 8'hFF, 2, 1};
    tbl2[2] = '{25'd6, 8'hFF, 2, 1};
    tbl2[3] = '{25'd7, 8'hFF, 2, 1};

    #12;
    chk("rst busy", {31'd0, busy1}, 32'd0);
    chk("rst pause_req", {31'd0, pause_req1}, 32'd0);
    chk("rst ram_sel", {31'd0, ram_sel1}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Session 1: normal reads plus out-of-range addresses.
    start_session();
    for (int i = 0; i < 6; i++) do_read(tbl1[i], $sformatf("s1[%0d]", i));
    chk("s1 byte_count", {21'd0, bc1}, 32'd4);
    chk("s1 checksum", {24'd0, cs1}, 32'hAA);
    upload = 1'b0;
    tick();
    chk("rel ram_sel", {31'd0, ram_sel1}, 32'd0);
    chk("rel pause_req", {31'd0, pause_req1}, 32'd0);
    chk("rel busy", {31'd0, busy1}, 32'd1);
    tick();
    chk("rel busy ack_hi", {31'd0, busy1}, 32'd1);
    ack = 1'b0;
    tick();
    chk("idle busy", {31'd0, busy1}, 32'd0);
    chk("held byte_count", {21'd0, bc1}, 32'd4);
    chk("held checksum", {24'd0, cs1}, 32'hAA);

    // Session 2: checksum wrap and the last valid address.
    start_session();
    for (int i = 0; i < 4; i++) do_read(tbl2[i], $sformatf("s2[%0d]", i));
    chk("wrap checksum", {24'd0, cs1}, 32'hFC);
    chk("wrap byte_count", {21'd0, bc1}, 32'd4);
    do_read('{25'd1023, 8'h04, 2, 1}, "s2 last");
    chk("last checksum", {24'd0, cs1}, 32'h00);
    chk("last byte_count", {21'd0, bc1}, 32'd5);

    // Asynchronous reset mid-session, checked before any clock edge.
    rst_n = 1'b0;
    #1;
    chk("arst din", {24'd0, if1.ioctl_din}, 32'd0);
    chk("arst wait", {31'd0, if1.ioctl_wait}, 32'd0);
    chk("arst pause_req", {31'd0, pause_req1}, 32'd0);
    chk("arst ram_sel", {31'd0, ram_sel1}, 32'd0);
    chk("arst ram_addr", {22'd0, ram_addr1}, 32'd0);
    chk("arst ram_rd", {31'd0, ram_rd1}, 32'd0);
    chk("arst busy", {31'd0, busy1}, 32'd0);
    chk("arst byte_count", {21'd0, bc1}, 32'd0);
    chk("arst checksum", {24'd0, cs1}, 32'd0);
    upload = 1'b0;
    ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst idle", {31'd0, busy1}, 32'd0);

    // Upload falls during a RAM_LAT=3 fetch.
    start_session();
    rd = 1'b1;
    addr = 25'd2;
    tick();
    rd = 1'b0;
    upload = 1'b0;
    chk("lat3 ram_rd", {31'd0, ram_rd3}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("lat3 sel held %0d", i), {31'd0, ram_sel3}, 32'd1);
      chk($sformatf("lat3 wait %0d", i), {31'd0, if3.ioctl_wait}, 32'd1);
    end
    tick();
    chk("lat3 din", {24'd0, if3.ioctl_din}, 32'h33);
    chk("lat3 sel drop", {31'd0, ram_sel3}, 32'd0);
    chk("lat3 pause_req", {31'd0, pause_req3}, 32'd0);
    chk("lat3 wait end", {31'd0, if3.ioctl_wait}, 32'd0);
    chk("lat3 byte_count", {21'd0, bc3}, 32'd1);
    tick();
    chk("lat3 busy ack_hi", {31'd0, busy3}, 32'd1);
    ack = 1'b0;
    tick();
    chk("lat3 idle", {31'd0, busy3}, 32'd0);

    // Upload aborted before the ack arrives.
    begin
      int sc0;
      sc0 = sel_cycles1;
      upload = 1'b1;
      ack = 1'b0;
      tick();
      chk("abort pause_req", {31'd0, pause_req1}, 32'd1);
      tick();
      tick();
      upload = 1'b0;
      tick();
      chk("abort pause drop", {31'd0, pause_req1}, 32'd0);
      chk("abort busy", {31'd0, busy1}, 32'd1);
      tick();
      chk("abort idle", {31'd0, busy1}, 32'd0);
      chk("abort sel never", sel_cycles1 - sc0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hiscore_upload_reader.md
Name: hiscore_upload_reader

Overview:
- Core-side responder for the HPS ioctl upload (read-back) path; it is the reverse of the ROM download write path.
- When the HPS reads during an upload, the block pauses the game CPU, takes over the shared work/NVRAM port and returns one byte per ioctl_rd.
- It inserts ioctl_wait while each byte is fetched, and keeps a byte count and an 8-bit checksum for the save image.
- It sits in emu between hps_io and the game core's RAM-port mux.

Parameters:
- AW, 10: RAM address width.
- SIZE, 1024: number of valid upload bytes; addresses at or above SIZE read as 8'hFF.
- RAM_LAT, 1: RAM read latency in clocks (1..4).

Ports:
- clk_sys  in  1: system clock; all logic is on its rising edge.
- RESET_N  in  1: asynchronous, active-low reset.
- ioctl_upload  in  1: level; HPS upload session active.
- ioctl_rd  in  1: one-clock read strobe from HPS.
- ioctl_addr  in  25: byte address, valid with ioctl_rd.
- ioctl_din  out  8: byte returned to HPS.
- ioctl_wait  out  1: HPS must not issue ioctl_rd while this is high.
- pause_req  out  1: request to the core to halt the CPU.
- pause_ack  in  1: core confirms the CPU is halted.
- ram_sel  out  1: 1 = this block owns the RAM port mux.
- ram_addr  out  AW: RAM read address.
- ram_rd  out  1: one-clock read enable.
- ram_q  in  8: RAM data, valid RAM_LAT clocks after ram_rd.
- busy  out  1: state != IDLE.
- byte_count  out  AW+1: bytes fetched from RAM this session.
- checksum  out  8: modulo-256 sum of the bytes fetched from RAM this session.

Behaviour:
- Reset (asynchronous, RESET_N=0): state IDLE, and every output is 0, including ioctl_din, byte_count and checksum.
- Outputs are registered.
- IDLE:
  - ioctl_wait=0.
  - If ioctl_upload=1 and pause_ack=0: set pause_req=1 and ioctl_wait=1, clear byte_count and checksum, go to WAIT_ACK.
- WAIT_ACK:
  - If ioctl_upload falls, go to RELEASE.
  - Else if pause_ack=1: set ram_sel=1 and ioctl_wait=0, go to READY.
- READY, on ioctl_rd with ioctl_addr < SIZE:
  - Set ram_addr=ioctl_addr[AW-1:0] and ram_rd=1 for one clock.
  - Set ioctl_wait=1 on that same edge.
  - Load the latency counter with RAM_LAT; go to FETCH.
- READY, on ioctl_rd with ioctl_addr >= SIZE:
  - Next edge: ioctl_din=8'hFF.
  - No ram_rd; ioctl_wait stays 0; byte_count and checksum are unchanged.
- READY, ioctl_upload=0 with no ioctl_rd: go to RELEASE.
- READY, ioctl_rd and upload falling in the same clock: the read is serviced first, then the block goes to RELEASE.
- FETCH:
  - The counter decrements each clock.
  - On the clock where it reaches 0: ioctl_din=ram_q, checksum+=ram_q (wraps), byte_count+=1, ioctl_wait=0.
  - Next state is READY, or RELEASE if ioctl_upload=0.
  - ioctl_wait is high for exactly RAM_LAT+1 clocks per in-range read.
- Any ioctl_rd received while in FETCH, WAIT_ACK or RELEASE is ignored (it is a protocol violation).
- ram_sel must never drop during FETCH. An upload that falls mid-fetch completes the fetch first.
- RELEASE:
  - Set ram_sel=0 and pause_req=0; wait for pause_ack=0, then go to IDLE.
  - A new ioctl_upload arriving during RELEASE is started from IDLE once the ack has dropped.
- byte_count saturates at 2^(AW+1)-1.
- checksum and byte_count hold their values after the session ends, until the next session starts.
- ioctl_din holds its last value between reads.

Decomposition:
- Package hiscore_pkg contains:
  - the state enum {IDLE, WAIT_ACK, READY, FETCH, RELEASE};
  - the localparam OOR_BYTE=8'hFF.
- One sub-module is natural: ram_port_mux (2:1 mux of CPU and upload address/read, selected by ram_sel). It is instantiated in emu, not inside this block.

Test Plan:
- Reset: assert RESET_N=0 mid-session → all outputs 0 immediately, with no clock required; state IDLE after release.
- Normal session: RAM = 11,22,33,44, RAM_LAT=1, ack after 3 clocks; read addresses 0..3 → ioctl_din = 11,22,33,44; ioctl_wait high 2 clocks per read; byte_count=4; checksum=8'hAA.
- Out of range: ioctl_rd with addr 1024 → ioctl_din=FF the next clock; ram_rd never asserted; ioctl_wait=0; byte_count unchanged.
- Upload drops mid-FETCH (RAM_LAT=3) → ram_sel held until the byte is captured, then ram_sel=0 and pause_req=0; IDLE only after pause_ack=0.
- Upload aborted in WAIT_ACK (no ack arrives) → ram_sel never asserted; pause_req drops; return to IDLE.
- Checksum wrap: 4 bytes of FF → checksum=8'hFC, byte_count=4.
